// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register and its stage wrappers.
// Holds the occupancy encoding, standard stage widths and control-bit positions.
package pipe_pkg;

    // Occupancy state; the encoding doubles as the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    localparam int XLEN    = 32;
    localparam int REG_IDX = 5;
    localparam int CTRL_W  = 4;

    // Payload widths of the standard stages (fields concatenated by the wrappers).
    localparam int IF_ID_PAYLOAD_W  = 2 * XLEN;               // pc, inst
    localparam int ID_EX_PAYLOAD_W  = 4 * XLEN + REG_IDX;     // pc, rs1, rs2, imm, rd
    localparam int EX_MEM_PAYLOAD_W = 2 * XLEN + REG_IDX;     // alu result, store data, rd
    localparam int MEM_WB_PAYLOAD_W = XLEN + REG_IDX;         // writeback data, rd

    localparam int IF_ID_CTRL_W  = CTRL_W;
    localparam int ID_EX_CTRL_W  = CTRL_W;
    localparam int EX_MEM_CTRL_W = CTRL_W;
    localparam int MEM_WB_CTRL_W = CTRL_W;

    // Bit positions inside the control field.
    localparam int RD_W_EN  = 0;
    localparam int CSR_W_EN = 1;
    localparam int MEM_R_EN = 2;
    localparam int MEM_W_EN = 3;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage register: two-entry skid buffer with valid/ready handshake,
// registered in_ready, synchronous flush and control-bit clearing on every bubble.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 32,
    parameter int CTRL_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [1:0]           out_count
);

    stage_state_t         state;
    logic                 ready_q;
    logic [PAYLOAD_W-1:0] main_payload;
    logic [PAYLOAD_W-1:0] skid_payload;
    logic [CTRL_W-1:0]    main_ctrl;
    logic [CTRL_W-1:0]    skid_ctrl;

    logic accept;
    logic pop;

    assign accept = in_valid & ready_q;
    assign pop    = out_valid & out_ready;

    // All outputs come straight from flops, so nothing combinational crosses the stage.
    assign in_ready    = ready_q;
    assign out_valid   = (state != EMPTY);
    assign out_payload = main_payload;
    assign out_ctrl    = main_ctrl;
    assign out_count   = state;

    // NOTE: sequential state uses non-blocking assignments only, so every branch
    // below reads the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= EMPTY;
            ready_q      <= 1'b1;
            main_payload <= '0;
            skid_payload <= '0;
            main_ctrl    <= '0;
            skid_ctrl    <= '0;
        end else if (flush) begin
            // Payloads hold their contents; only control bits are killed.
            state     <= EMPTY;
            ready_q   <= 1'b1;
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_payload <= in_payload;
                        main_ctrl    <= in_ctrl;
                        state        <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_payload <= in_payload;
                        main_ctrl    <= in_ctrl;
                    end else if (accept) begin
                        skid_payload <= in_payload;
                        skid_ctrl    <= in_ctrl;
                        state        <= FULL;
                        ready_q      <= 1'b0;
                    end else if (pop) begin
                        main_ctrl <= '0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can move the state.
                    if (pop) begin
                        main_payload <= skid_payload;
                        main_ctrl    <= skid_ctrl;
                        skid_ctrl    <= '0;
                        state        <= ONE;
                        ready_q      <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    ready_q   <= 1'b1;
                    main_ctrl <= '0;
                    skid_ctrl <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: FIFO reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_skid_reg;

    localparam int PW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_payload;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_payload;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    out_count;

    int checks = 0;
    int errors = 0;

    pipe_skid_reg #(.PAYLOAD_W(PW), .CTRL_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .in_ctrl     (in_ctrl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .out_ctrl    (out_ctrl),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of at most two entries.
    typedef struct {
        logic [PW-1:0] p;
        logic [CW-1:0] c;
    } ent_t;

    ent_t          q[$];
    logic [PW-1:0] last_p;

    always @(posedge clk or posedge rst) begin : model
        bit   acc;
        bit   pp;
        ent_t e;
        if (rst) begin
            q.delete();
            last_p = '0;
        end else begin
            acc = in_valid && (q.size() < 2);
            pp  = (q.size() > 0) && out_ready;
            e.p = in_payload;
            e.c = in_ctrl;
            if (flush) begin
                q.delete();
            end else begin
                if (pp) void'(q.pop_front());
                if (acc) q.push_back(e);
            end
            if (q.size() > 0) last_p = q[0].p;
        end
    end

    always @(negedge clk) begin : compare
        check("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("m_out_count", 64'(out_count), 64'(q.size()));
        check("m_in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() != 0) begin
            check("m_out_payload", 64'(out_payload), 64'(q[0].p));
            check("m_out_ctrl", 64'(out_ctrl), 64'(q[0].c));
        end else begin
            check("m_idle_payload", 64'(out_payload), 64'(last_p));
            check("m_idle_ctrl", 64'(out_ctrl), 64'd0);
        end
    end

    task automatic drive(input logic v, input logic [PW-1:0] p, input logic [CW-1:0] c);
        in_valid   = v;
        in_payload = p;
        in_ctrl    = c;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 4'hF);   // ignored while in reset
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_payload", 64'(out_payload), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        rst = 1'b0;
        drive(1'b0, '0, '0);

        // Streaming: one entry per cycle, each visible one cycle after its input.
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, PW'(i), 4'hF);
            @(negedge clk);
            check("stream_payload", 64'(out_payload), 64'(i));
            check("stream_ctrl", 64'(out_ctrl), 64'hF);
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        drive(1'b0, '0, '0);
        @(negedge clk);
        check("stream_drain_valid", 64'(out_valid), 64'd0);

        // Back-pressure: A and B fill the buffer, C waits.
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 4'h1);
        @(negedge clk);
        drive(1'b1, 32'hB, 4'h2);
        @(negedge clk);
        drive(1'b1, 32'hC, 4'h3);
        check("bp_count_full", 64'(out_count), 64'd2);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_head_a", 64'(out_payload), 64'hA);
        @(negedge clk);
        check("bp_c_held", 64'(out_count), 64'd2);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_head_b", 64'(out_payload), 64'hB);
        check("bp_count_one", 64'(out_count), 64'd1);
        @(negedge clk);
        check("bp_head_c", 64'(out_payload), 64'hC);
        check("bp_ctrl_c", 64'(out_ctrl), 64'h3);
        drive(1'b0, '0, '0);
        @(negedge clk);
        check("bp_drained", 64'(out_count), 64'd0);

        // Flush while FULL with D offered on the input.
        out_ready = 1'b0;
        drive(1'b1, 32'hE, 4'hE);
        @(negedge clk);
        drive(1'b1, 32'hF0, 4'hF);
        @(negedge clk);
        check("fl_count_full", 64'(out_count), 64'd2);
        drive(1'b1, 32'hD, 4'hD);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_out_ctrl", 64'(out_ctrl), 64'd0);
        check("fl_out_count", 64'(out_count), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        check("fl_payload_kept", 64'(out_payload), 64'hE);
        out_ready = 1'b1;
        @(negedge clk);
        check("fl_d_never_out", 64'(out_valid), 64'd0);

        // Bubble clearing: control drops, payload stays.
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 4'b0101);
        @(negedge clk);
        drive(1'b0, '0, '0);
        check("bub_ctrl_live", 64'(out_ctrl), 64'h5);
        out_ready = 1'b1;
        @(negedge clk);
        check("bub_ctrl_zero", 64'(out_ctrl), 64'd0);
        check("bub_payload_kept", 64'(out_payload), 64'h55);
        check("bub_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges while FULL.
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 4'h9);
        @(negedge clk);
        drive(1'b1, 32'h22, 4'hA);
        @(negedge clk);
        drive(1'b0, '0, '0);
        check("ar_count_full", 64'(out_count), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_out_count", 64'(out_count), 64'd0);
        check("ar_out_ctrl", 64'(out_ctrl), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic with occasional flush; the compare process does the checking.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 31) == 0);
        end
        @(negedge clk);
        drive(1'b0, '0, '0);
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("final_drained", 64'(out_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
